// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns latched EX/MEM memory ops into a held
// dcache request, stalls the pipeline until dhit, captures load data and halts.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | latched instruction not yet serviced
//   WAIT    | request issued, waiting for dhit
//   DONE    | latched instruction's access complete, no re-issue
module mem_access_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN_dl,
  input  logic              dmemWEN_dl,
  input  logic [WORD_W-1:0] porto_l,
  input  logic [WORD_W-1:0] portb_dl,
  input  logic              halt_dl,
  input  logic              advance,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] dmemload_l,
  output logic              halt,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;
  logic   issue_ok;
  logic   req;

  // A completed access must not re-issue while the latch is held for other reasons.
  assign issue_ok  = (state != DONE) & ~halt;
  assign dmemWEN   = dmemWEN_dl & issue_ok;
  assign dmemREN   = dmemREN_dl & ~dmemWEN_dl & issue_ok;
  assign req       = dmemREN | dmemWEN;
  assign mem_stall = req & ~dhit;
  assign dmemaddr  = {porto_l[WORD_W-1:2], 2'b00};
  assign dmemstore = portb_dl;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (advance) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req && dhit) begin
            next_state = DONE;
          end else if (req) begin
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end
        WAIT: begin
          if (req && dhit) begin
            next_state = DONE;
          end else begin
            next_state = WAIT;
          end
        end
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dmemload_l <= '0;
    end else if (dmemREN && dhit) begin
      dmemload_l <= dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt <= 1'b0;
    end else if (halt_dl && !mem_stall) begin
      halt <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (mem_stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; counter narrowed to 4 bits so saturation is reachable.
module tb_mem_access_ctrl;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  logic              CLK;
  logic              nRST;
  logic              dmemREN_dl;
  logic              dmemWEN_dl;
  logic [WORD_W-1:0] porto_l;
  logic [WORD_W-1:0] portb_dl;
  logic              halt_dl;
  logic              advance;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              mem_stall;
  logic [WORD_W-1:0] dmemload_l;
  logic              halt;
  logic [CNT_W-1:0]  stall_cycles;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN_dl(dmemREN_dl), .dmemWEN_dl(dmemWEN_dl),
    .porto_l(porto_l), .portb_dl(portb_dl), .halt_dl(halt_dl),
    .advance(advance), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .dmemload_l(dmemload_l),
    .halt(halt), .stall_cycles(stall_cycles)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // advance while a request is stalled is a protocol violation
  always @(posedge CLK) begin
    if (nRST && advance) check("adv_during_stall", {31'd0, mem_stall}, 32'd0);
  end

  logic [31:0] ld_data [4];
  int nstall;
  int nwen;

  initial begin
    ld_data[0] = 32'h1111_1111;
    ld_data[1] = 32'h2222_2222;
    ld_data[2] = 32'h3333_3333;
    ld_data[3] = 32'h4444_4444;

    nRST = 1'b0; dmemREN_dl = 0; dmemWEN_dl = 0; porto_l = '0; portb_dl = '0;
    halt_dl = 0; advance = 0; dhit = 0; dmemload = '0;
    #1;
    check("rst_halt", {31'd0, halt}, 0);
    check("rst_load_l", dmemload_l, 0);
    check("rst_cnt", {28'd0, stall_cycles}, 0);
    check("rst_ren", {31'd0, dmemREN}, 0);
    check("rst_stall", {31'd0, mem_stall}, 0);
    check("rst_addr", dmemaddr, 0);
    step();
    nRST = 1'b1;

    // load with a 3-cycle miss, hit on the 4th
    dmemREN_dl = 1; porto_l = 32'h0000_0104; nstall = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin dhit = 1; dmemload = 32'hDEAD_BEEF; advance = 1; end
      #1;
      if (mem_stall) nstall++;
      check("ld_ren", {31'd0, dmemREN}, 1);
      check("ld_addr", dmemaddr, 32'h104);
      step();
    end
    dmemREN_dl = 0; advance = 0; dhit = 0;
    #1;
    check("ld_nstall", nstall, 3);
    check("ld_data", dmemload_l, 32'hDEAD_BEEF);
    check("ld_cnt", {28'd0, stall_cycles}, 3);

    // store hit in first cycle, latch then held for two cycles
    dmemWEN_dl = 1; porto_l = 32'h0000_0203; portb_dl = 32'h1234_5678; nwen = 0;
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 0);
      #1;
      if (dmemWEN) nwen++;
      check("st_stall", {31'd0, mem_stall}, 0);
      if (i == 0) begin
        check("st_addr", dmemaddr, 32'h200);
        check("st_data", dmemstore, 32'h1234_5678);
      end else begin
        check("st_done_wen", {31'd0, dmemWEN}, 0);
      end
      step();
    end
    check("st_wen_pulses", nwen, 1);
    advance = 1; dhit = 0;
    step();
    advance = 0; dmemWEN_dl = 0;
    check("st_cnt", {28'd0, stall_cycles}, 3);

    // back-to-back loads, immediate hits, advancing every cycle
    advance = 1; dhit = 1; dmemREN_dl = 1;
    for (int i = 0; i < 4; i++) begin
      porto_l = 32'h300 + i * 4;
      dmemload = ld_data[i];
      #1;
      check("b2b_ren", {31'd0, dmemREN}, 1);
      check("b2b_stall", {31'd0, mem_stall}, 0);
      check("b2b_addr", dmemaddr, 32'h300 + i * 4);
      step();
      check("b2b_data", dmemload_l, ld_data[i]);
    end
    advance = 0; dhit = 0; dmemREN_dl = 0;
    #1;
    check("b2b_cnt", {28'd0, stall_cycles}, 3);

    // read and write both set: write wins
    dmemREN_dl = 1; dmemWEN_dl = 1; porto_l = 32'h10;
    #1;
    check("both_wen", {31'd0, dmemWEN}, 1);
    check("both_ren", {31'd0, dmemREN}, 0);
    check("both_stall", {31'd0, mem_stall}, 1);
    dhit = 1; advance = 1;
    #1;
    check("both_hit_stall", {31'd0, mem_stall}, 0);
    step();
    dmemREN_dl = 0; dmemWEN_dl = 0; dhit = 0; advance = 0;
    check("both_cnt", {28'd0, stall_cycles}, 3);

    // reset while a load waits
    dmemREN_dl = 1; porto_l = 32'h40;
    step();
    step();
    check("rw_cnt_pre", {28'd0, stall_cycles}, 5);
    #2 nRST = 0;
    #1;
    check("rw_cnt", {28'd0, stall_cycles}, 0);
    check("rw_load_l", dmemload_l, 0);
    check("rw_ren_idle", {31'd0, dmemREN}, 1);
    nRST = 1;
    #1;
    check("rw_reissue_ren", {31'd0, dmemREN}, 1);
    check("rw_reissue_stall", {31'd0, mem_stall}, 1);
    step();
    dhit = 1; advance = 1; dmemload = 32'hA5A5_0001;
    step();
    dmemREN_dl = 0; dhit = 0; advance = 0;
    check("rw_data", dmemload_l, 32'hA5A5_0001);
    check("rw_cnt_post", {28'd0, stall_cycles}, 1);

    // long miss saturates the 4-bit counter
    dmemREN_dl = 1; porto_l = 32'h80;
    repeat (20) step();
    check("sat_cnt", {28'd0, stall_cycles}, 15);
    check("sat_stall", {31'd0, mem_stall}, 1);
    dhit = 1; advance = 1;
    step();
    dmemREN_dl = 0; dhit = 0; advance = 0;
    check("sat_hold", {28'd0, stall_cycles}, 15);

    // halt with no op, then requests are suppressed
    halt_dl = 1;
    #1;
    check("halt_pre", {31'd0, halt}, 0);
    step();
    halt_dl = 0;
    check("halt_set", {31'd0, halt}, 1);
    dmemREN_dl = 1; porto_l = 32'h500;
    #1;
    check("halt_ren", {31'd0, dmemREN}, 0);
    check("halt_stall", {31'd0, mem_stall}, 0);
    dmemWEN_dl = 1;
    #1;
    check("halt_wen", {31'd0, dmemWEN}, 0);
    step();
    check("halt_sticky", {31'd0, halt}, 1);
    dmemREN_dl = 0; dmemWEN_dl = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
